// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the fetch stage and its prefetch buffer.
package cpu_pkg;

    localparam int          DATA_W     = 22;
    localparam logic [21:0] NOP_INSTR  = 22'h0;
    localparam logic [3:0]  PC_REG_IDX = 4'b1011;
    localparam int          PC_STEP    = 4;
    localparam int          PC_AHEAD   = 8;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two ring buffer with flush, simultaneous push/pop when full.
module fetch_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one-outstanding req/ack memory interface, prefetch FIFO and
// the decode-facing output register, with stall and branch redirect handling.
module fetch_stage #(
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              stall_d,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] instruction_decode,
    output logic [DATA_W-1:0] pc_plus_8,
    output logic              valid_decode
);

    import cpu_pkg::*;

    localparam int                CNT_W  = $clog2(DEPTH) + 1;
    localparam int                FIFO_W = 2 * DATA_W;
    localparam logic [DATA_W-1:0] NOP_W  = DATA_W'(NOP_INSTR);

    logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc8_q, pc8_d;
    logic              valid_q, valid_d;

    logic              ack_fire;
    logic              accept;
    logic              outstanding_next;
    logic [FIFO_W-1:0] ack_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic [FIFO_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  fifo_count_next;

    fetch_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (ack_entry),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Returned word is kept unless it answers a request that a redirect has made stale.
    always_comb begin
        ack_fire  = req_q & imem_ack;
        accept    = ack_fire & ~discard_q & ~branch_taken;
        ack_entry = {imem_rdata, addr_q + DATA_W'(PC_AHEAD)};
    end

    always_comb begin
        instr_d    = instr_q;
        pc8_d      = pc8_q;
        valid_d    = valid_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = branch_taken;
        if (branch_taken) begin
            instr_d = NOP_W;
            pc8_d   = '0;
            valid_d = 1'b0;
        end else if (!stall_d) begin
            if (!fifo_empty) begin
                instr_d   = fifo_rdata[FIFO_W-1:DATA_W];
                pc8_d     = fifo_rdata[DATA_W-1:0];
                valid_d   = 1'b1;
                fifo_pop  = 1'b1;
                fifo_push = accept;
            end else if (accept) begin
                instr_d = ack_entry[FIFO_W-1:DATA_W];
                pc8_d   = ack_entry[DATA_W-1:0];
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_W;
                pc8_d   = '0;
                valid_d = 1'b0;
            end
        end else begin
            fifo_push = accept & ~fifo_full;
        end
    end

    // Issue decisions look at the FIFO occupancy after this edge so it never overfills.
    always_comb begin
        if (fifo_flush) fifo_count_next = '0;
        else            fifo_count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

        outstanding_next = req_q & ~ack_fire;
        discard_d        = outstanding_next & (discard_q | branch_taken);

        fetch_pc_d = fetch_pc_q;
        if (branch_taken)  fetch_pc_d = branch_target;
        else if (accept)   fetch_pc_d = fetch_pc_q + DATA_W'(PC_STEP);

        req_d  = 1'b0;
        addr_d = fetch_pc_d;
        if (outstanding_next) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else if (32'(fifo_count_next) < DEPTH) begin
            req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            discard_q  <= 1'b0;
            instr_q    <= NOP_W;
            pc8_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            pc8_q      <= pc8_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req           = req_q;
    assign imem_addr          = addr_q;
    assign instruction_decode = instr_q;
    assign pc_plus_8          = pc8_q;
    assign valid_decode       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a configurable-latency instruction memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [21:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [21:0] imem_rdata = '0;
    logic        stall_d = 1'b0;
    logic        branch_taken = 1'b0;
    logic [21:0] branch_target = '0;
    logic [21:0] instruction_decode;
    logic [21:0] pc_plus_8;
    logic        valid_decode;

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int wait_cnt = 0;

    fetch_stage #(
        .DATA_W   (22),
        .DEPTH    (4),
        .RESET_PC (22'h0)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_ack           (imem_ack),
        .imem_rdata         (imem_rdata),
        .stall_d            (stall_d),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .instruction_decode (instruction_decode),
        .pc_plus_8          (pc_plus_8),
        .valid_decode       (valid_decode)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] mem_word(input logic [21:0] a);
        return a ^ 22'h2A5A5A;
    endfunction

    // Memory acks after mem_wait idle cycles of an asserted request.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end else if (imem_req) begin
                if (wait_cnt >= mem_wait) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic stall, input logic br, input logic [21:0] tgt);
        stall_d       = stall;
        branch_taken  = br;
        branch_target = tgt;
    endtask

    task automatic check_dec(input string tag, input logic v, input logic [21:0] a);
        checkOutput({tag, "_valid"}, 32'(valid_decode), 32'(v));
        if (v) begin
            checkOutput({tag, "_instr"}, 32'(instruction_decode), 32'(mem_word(a)));
            checkOutput({tag, "_pc8"}, 32'(pc_plus_8), 32'(a + 22'd8));
        end else begin
            checkOutput({tag, "_nop"}, 32'(instruction_decode), 32'h0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 22'h0);
        mem_wait = 0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        checkOutput("rst_req", 32'(imem_req), 32'h0);
        checkOutput("rst_addr", 32'(imem_addr), 32'h0);
        checkOutput("rst_pc8", 32'(pc_plus_8), 32'h0);
        check_dec("rst", 1'b0, 22'h0);

        // 1: zero-wait streaming
        tick();
        checkOutput("t1_req", 32'(imem_req), 32'h1);
        checkOutput("t1_addr", 32'(imem_addr), 32'h0);
        check_dec("t1_c1", 1'b0, 22'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_dec("t1_stream", 1'b1, 22'(4 * k));
        end

        // 2: three-cycle memory response
        do_reset();
        mem_wait = 2;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checkOutput("t2_req", 32'(imem_req), 32'h1);
            checkOutput("t2_addr_hold", 32'(imem_addr), 32'h0);
            check_dec("t2_wait", 1'b0, 22'h0);
        end
        tick();
        check_dec("t2_w0", 1'b1, 22'h0);
        checkOutput("t2_addr4", 32'(imem_addr), 32'h4);
        tick();
        check_dec("t2_bub1", 1'b0, 22'h0);
        checkOutput("t2_addr4_hold", 32'(imem_addr), 32'h4);
        tick();
        check_dec("t2_bub2", 1'b0, 22'h0);
        tick();
        check_dec("t2_w4", 1'b1, 22'h4);

        // 3: stall fills FIFO, output frozen, drain in order
        do_reset();
        tick();
        tick();
        check_dec("t3_first", 1'b1, 22'h0);
        applyStimulus(1'b1, 1'b0, 22'h0);
        for (int k = 3; k <= 5; k++) tick();
        for (int k = 6; k <= 12; k++) begin
            tick();
            checkOutput("t3_req_low", 32'(imem_req), 32'h0);
            checkOutput("t3_addr", 32'(imem_addr), 32'h14);
            check_dec("t3_frozen", 1'b1, 22'h0);
        end
        applyStimulus(1'b0, 1'b0, 22'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_dec("t3_drain", 1'b1, 22'(4 + 4 * k));
        end

        // 4: redirect while 0x20 is in flight
        do_reset();
        for (int k = 1; k <= 8; k++) tick();
        mem_wait = 3;
        tick();
        checkOutput("t4_addr20", 32'(imem_addr), 32'h20);
        check_dec("t4_pre", 1'b1, 22'h1C);
        applyStimulus(1'b0, 1'b1, 22'h100);
        tick();
        applyStimulus(1'b0, 1'b0, 22'h0);
        check_dec("t4_bub", 1'b0, 22'h0);
        checkOutput("t4_hold20", 32'(imem_addr), 32'h20);
        tick();
        mem_wait = 0;
        checkOutput("t4_hold20b", 32'(imem_addr), 32'h20);
        tick();
        check_dec("t4_discard", 1'b0, 22'h0);
        tick();
        checkOutput("t4_addr100", 32'(imem_addr), 32'h100);
        checkOutput("t4_req100", 32'(imem_req), 32'h1);
        check_dec("t4_bub2", 1'b0, 22'h0);
        tick();
        check_dec("t4_tgt", 1'b1, 22'h100);
        tick();
        check_dec("t4_tgt4", 1'b1, 22'h104);

        // 5: redirect and stall in the same cycle
        do_reset();
        for (int k = 1; k <= 4; k++) tick();
        check_dec("t5_pre", 1'b1, 22'h8);
        applyStimulus(1'b1, 1'b1, 22'h200);
        tick();
        check_dec("t5_bub", 1'b0, 22'h0);
        checkOutput("t5_addr200", 32'(imem_addr), 32'h200);
        applyStimulus(1'b1, 1'b0, 22'h0);
        tick();
        check_dec("t5_stallbub", 1'b0, 22'h0);
        applyStimulus(1'b0, 1'b0, 22'h0);
        tick();
        check_dec("t5_tgt", 1'b1, 22'h200);
        tick();
        check_dec("t5_tgt4", 1'b1, 22'h204);

        // 6a: asynchronous reset mid-handshake
        do_reset();
        for (int k = 1; k <= 3; k++) tick();
        mem_wait = 2;
        tick();
        checkOutput("t6_req", 32'(imem_req), 32'h1);
        checkOutput("t6_addrC", 32'(imem_addr), 32'hC);
        check_dec("t6_pre", 1'b1, 22'h8);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_req", 32'(imem_req), 32'h0);
        checkOutput("t6_rst_addr", 32'(imem_addr), 32'h0);
        checkOutput("t6_rst_pc8", 32'(pc_plus_8), 32'h0);
        check_dec("t6_rst", 1'b0, 22'h0);
        tick();
        rst = 1'b1;
        mem_wait = 0;
        tick();
        checkOutput("t6_req_after", 32'(imem_req), 32'h1);
        checkOutput("t6_addr_after", 32'(imem_addr), 32'h0);

        // 6b: address wraps past 22'h3FFFFC
        do_reset();
        for (int k = 1; k <= 3; k++) tick();
        applyStimulus(1'b0, 1'b1, 22'h3FFFF8);
        tick();
        applyStimulus(1'b0, 1'b0, 22'h0);
        checkOutput("t6_addr_tgt", 32'(imem_addr), 32'h3FFFF8);
        tick();
        checkOutput("t6_instr_f8", 32'(instruction_decode), 32'(mem_word(22'h3FFFF8)));
        checkOutput("t6_pc8_wrap", 32'(pc_plus_8), 32'h0);
        checkOutput("t6_addr_fc", 32'(imem_addr), 32'h3FFFFC);
        tick();
        checkOutput("t6_instr_fc", 32'(instruction_decode), 32'(mem_word(22'h3FFFFC)));
        checkOutput("t6_pc8_4", 32'(pc_plus_8), 32'h4);
        checkOutput("t6_addr_wrap", 32'(imem_addr), 32'h0);
        tick();
        check_dec("t6_wrapped", 1'b1, 22'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
